// File: rtl/seq_pkg.sv
// Shared definitions for the sequence-pattern path: transmitter FSM states
// and the default geometry paired between the transmitter and the detectors.
package seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_GAP  = 2'd2,
        ST_DONE = 2'd3
    } tx_state_t;

    localparam int DEF_W     = 8;
    localparam int DEF_CNT_W = 4;
    localparam int DEF_GAP   = 1;

endpackage

// File: rtl/seq_pattern_tx.sv
// Serial pattern transmitter: sends a latched pattern MSB-first, repeated
// reps times with forced-zero gap bits between repetitions.
module seq_pattern_tx
    import seq_pkg::*;
#(
    parameter int W     = DEF_W,
    parameter int CNT_W = DEF_CNT_W,
    parameter int GAP   = DEF_GAP
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [W-1:0]             req_pattern,
    input  logic [$clog2(W+1)-1:0]   req_len,
    input  logic [CNT_W-1:0]         req_reps,
    input  logic                     abort,
    output logic                     x,
    output logic                     x_valid,
    output logic                     busy,
    output logic                     done
);

    localparam int LW = $clog2(W + 1);
    localparam int GW = (GAP > 0) ? $clog2(GAP + 1) : 1;

    tx_state_t         state_q, state_d;
    logic [W-1:0]      sh_q, sh_d;
    logic [W-1:0]      pat_q, pat_d;
    logic [LW-1:0]     len_q, len_d;
    logic [LW-1:0]     bit_q, bit_d;
    logic [CNT_W-1:0]  rep_q, rep_d;
    logic [GW-1:0]     gap_q, gap_d;
    logic              x_q, x_d;
    logic              xv_q, xv_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic              accept;
    logic [LW-1:0]     len_c;
    logic [LW-1:0]     shamt;
    logic [W-1:0]      aligned;
    logic [CNT_W-1:0]  reps_c;

    assign req_ready = (state_q == ST_IDLE) && !abort;
    assign accept    = req_valid && req_ready;

    assign x       = x_q;
    assign x_valid = xv_q;
    assign busy    = busy_q;
    assign done    = done_q;

    always_comb begin
        // Left-align the used bits so the first bit always sits at W-1.
        len_c   = (req_len > LW'(W)) ? LW'(W) : req_len;
        shamt   = LW'(W) - len_c;
        aligned = req_pattern << shamt;
        reps_c  = (req_reps == '0) ? CNT_W'(1) : req_reps;
    end

    always_comb begin
        state_d = state_q;
        sh_d    = sh_q;
        pat_d   = pat_q;
        len_d   = len_q;
        bit_d   = bit_q;
        rep_d   = rep_q;
        gap_d   = gap_q;
        x_d     = 1'b0;
        xv_d    = 1'b0;
        busy_d  = 1'b0;
        done_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    pat_d  = aligned;
                    len_d  = len_c;
                    rep_d  = reps_c;
                    busy_d = 1'b1;
                    if (len_c == '0) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = ST_SEND;
                        x_d     = aligned[W-1];
                        xv_d    = 1'b1;
                        sh_d    = aligned << 1;
                        bit_d   = len_c - LW'(1);
                    end
                end
            end
            ST_SEND: begin
                busy_d = 1'b1;
                // bit_q counts bits still to send after the one on x now.
                if (bit_q != '0) begin
                    x_d   = sh_q[W-1];
                    xv_d  = 1'b1;
                    sh_d  = sh_q << 1;
                    bit_d = bit_q - LW'(1);
                end else if (rep_q > CNT_W'(1)) begin
                    rep_d = rep_q - CNT_W'(1);
                    xv_d  = 1'b1;
                    if (GAP > 0) begin
                        state_d = ST_GAP;
                        gap_d   = GW'(GAP - 1);
                    end else begin
                        x_d   = pat_q[W-1];
                        sh_d  = pat_q << 1;
                        bit_d = len_q - LW'(1);
                    end
                end else begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                end
            end
            ST_GAP: begin
                busy_d = 1'b1;
                xv_d   = 1'b1;
                if (gap_q != '0) begin
                    gap_d = gap_q - GW'(1);
                end else begin
                    state_d = ST_SEND;
                    x_d     = pat_q[W-1];
                    sh_d    = pat_q << 1;
                    bit_d   = len_q - LW'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
        endcase

        if (abort && (state_q != ST_IDLE)) begin
            state_d = ST_IDLE;
            x_d     = 1'b0;
            xv_d    = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            sh_q    <= '0;
            pat_q   <= '0;
            len_q   <= '0;
            bit_q   <= '0;
            rep_q   <= '0;
            gap_q   <= '0;
            x_q     <= 1'b0;
            xv_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sh_q    <= sh_d;
            pat_q   <= pat_d;
            len_q   <= len_d;
            bit_q   <= bit_d;
            rep_q   <= rep_d;
            gap_q   <= gap_d;
            x_q     <= x_d;
            xv_q    <= xv_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

endmodule
